// File: rtl/dice_cgra_pkg.sv
// Shared types and widths for the DICE CGRA thread-ID latency pipeline.
package dice_cgra_pkg;

    localparam int unsigned NUM_TID     = 512;
    localparam int unsigned MAX_LATENCY = 32;

    function automatic int unsigned tid_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned lat_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

    localparam int unsigned TID_W = tid_width(NUM_TID);
    localparam int unsigned LAT_W = lat_width(MAX_LATENCY);
    localparam int unsigned CNT_W = tid_width(NUM_TID);
    localparam int unsigned IDX_W = $clog2(MAX_LATENCY);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} tid_pipe_state_e;

    typedef struct packed {
        logic             valid;
        logic [TID_W-1:0] tid;
    } tid_slot_t;

endpackage

// File: rtl/dice_cgra_tid_pipeline_if.sv
// Dispatch and writeback signals between dispatcher, TID pipeline and RF address converter.
interface dice_cgra_tid_pipeline_if;
    import dice_cgra_pkg::*;

    logic [TID_W-1:0] in_tid;
    logic             in_valid;
    logic             in_ready;
    logic [TID_W-1:0] out_tid;
    logic             out_valid;

    modport master (output in_tid, in_valid, input in_ready, out_tid, out_valid);
    modport slave  (input in_tid, in_valid, output in_ready, out_tid, out_valid);
endinterface

// File: rtl/dice_cgra_tid_pipeline_delay_line.sv
// Stall-able shift register of TID slots with a selectable output tap.
module dice_tid_delay_line
    import dice_cgra_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             stall_i,
    input  tid_slot_t        slot_i,
    input  logic [IDX_W-1:0] tap_sel_i,
    output tid_slot_t        tap_o
);

    tid_slot_t stage_q [MAX_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '{default: '0};
        end else if (clr_i) begin
            stage_q <= '{default: '0};
        end else if (!stall_i) begin
            stage_q[0] <= slot_i;
            for (int i = 1; i < int'(MAX_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tap_o = stage_q[tap_sel_i];

endmodule

// File: rtl/dice_cgra_tid_pipeline.sv
// Batch-controlled TID latency pipeline: dispatch handshake, stall freeze, retire accounting.
// Optional DICE_TID_PIPE_PERF_EN adds saturating stall/bubble performance counters.
module dice_cgra_tid_pipeline
    import dice_cgra_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    cfg_num_tid_i,
    input  logic [LAT_W-1:0]    cfg_latency_i,
    input  logic                stall_i,
    dice_cgra_tid_pipeline_if.slave tid_if,
    output logic [CNT_W-1:0]    inflight_o,
    output logic                busy_o,
    output logic                batch_done_o
`ifdef DICE_TID_PIPE_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles_o,
    output logic [31:0]         perf_bubble_cycles_o
`endif
);

    tid_pipe_state_e  state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] num_q, num_d, disp_q, disp_d, ret_q, ret_d, infl_q, infl_d;
    logic             in_ready_c, busy_c, done_c;
    logic             start_acc, accept, retire, bypass;
    tid_slot_t        slot_in, tap;
    logic [IDX_W-1:0] tap_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (cfg_num_tid_i == '0) ? DONE : RUN;
            RUN:     if (accept && (disp_q + CNT_W'(1) == num_q)) state_d = DRAIN;
            DRAIN:   if (ret_q + CNT_W'(retire) == num_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_i) state_d = IDLE;
    end

    always_comb begin
        in_ready_c = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        in_ready_c = (state_q == RUN) && !stall_i && (disp_q < num_q);
        busy_c     = (state_q != IDLE);
        done_c     = (state_q == DONE);
    end

    assign start_acc = start_i && (state_q == IDLE);
    assign accept    = tid_if.in_valid && in_ready_c;
    assign bypass    = (lat_q == '0);
    assign tap_sel   = bypass ? '0 : IDX_W'(lat_q - LAT_W'(1));
    // Bypassed entries never enter the line, so a later longer-latency batch sees no ghosts.
    assign slot_in   = '{valid: accept && !bypass, tid: tid_if.in_tid};

    dice_tid_delay_line u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_i || start_acc),
        .stall_i   (stall_i),
        .slot_i    (slot_in),
        .tap_sel_i (tap_sel),
        .tap_o     (tap)
    );

    assign retire           = bypass ? accept : (tap.valid && !stall_i);
    assign tid_if.in_ready  = in_ready_c;
    assign tid_if.out_valid = retire;
    assign tid_if.out_tid   = !retire ? '0 : (bypass ? tid_if.in_tid : tap.tid);
    assign inflight_o       = infl_q;
    assign busy_o           = busy_c;
    assign batch_done_o     = done_c;

    always_comb begin
        lat_d  = lat_q;
        num_d  = num_q;
        disp_d = disp_q + CNT_W'(accept);
        ret_d  = ret_q + CNT_W'(retire);
        infl_d = infl_q + CNT_W'(accept) - CNT_W'(retire);
        if (start_acc) begin
            lat_d  = (cfg_latency_i > LAT_W'(MAX_LATENCY)) ? LAT_W'(MAX_LATENCY) : cfg_latency_i;
            num_d  = cfg_num_tid_i;
            disp_d = '0;
            ret_d  = '0;
        end
        if (clr_i) begin
            lat_d  = '0;
            num_d  = '0;
            disp_d = '0;
            ret_d  = '0;
            infl_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q  <= '0;
            num_q  <= '0;
            disp_q <= '0;
            ret_q  <= '0;
            infl_q <= '0;
        end else begin
            lat_q  <= lat_d;
            num_q  <= num_d;
            disp_q <= disp_d;
            ret_q  <= ret_d;
            infl_q <= infl_d;
        end
    end

`ifdef DICE_TID_PIPE_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        if (busy_c && stall_i && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        if (in_ready_c && !tid_if.in_valid && (perf_bubble_q != '1))
            perf_bubble_d = perf_bubble_q + 32'd1;
        if (clr_i || start_acc) begin
            perf_stall_d  = '0;
            perf_bubble_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_stall_cycles_o  = perf_stall_q;
    assign perf_bubble_cycles_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_dice_cgra_tid_pipeline.sv
// Bench for dice_cgra_tid_pipeline: directed and randomized batches against a transaction-level model.
module tb_dice_cgra_tid_pipeline;
    import dice_cgra_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, d_clr, d_start, d_stall, d_valid;
    logic [CNT_W-1:0] d_num;
    logic [LAT_W-1:0] d_lat;
    logic [TID_W-1:0] d_tid;
    logic [CNT_W-1:0] inflight;
    logic             busy, batch_done;
`ifdef DICE_TID_PIPE_PERF_EN
    logic [31:0]      perf_stall, perf_bubble;
`endif

    dice_cgra_tid_pipeline_if ifc();
    assign ifc.in_valid = d_valid;
    assign ifc.in_tid   = d_tid;

    dice_cgra_tid_pipeline dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (d_clr),
        .start_i       (d_start),
        .cfg_num_tid_i (d_num),
        .cfg_latency_i (d_lat),
        .stall_i       (d_stall),
        .tid_if        (ifc),
        .inflight_o    (inflight),
        .busy_o        (busy),
        .batch_done_o  (batch_done)
`ifdef DICE_TID_PIPE_PERF_EN
        ,
        .perf_stall_cycles_o  (perf_stall),
        .perf_bubble_cycles_o (perf_bubble)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: a batch is open until every dispatched TID has come back.
    bit m_open, m_done;
    int m_num, m_lat, m_sent, m_got, m_pstall, m_pbub;
    int m_age[$];
    int m_tidq[$];

    int cyc, first_acc, first_ret, obs_acc, obs_ret, obs_peak;
    bit obs_ready_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_open = 0; m_done = 0; m_num = 0; m_lat = 0; m_sent = 0; m_got = 0;
        m_pstall = 0; m_pbub = 0;
        m_age.delete(); m_tidq.delete();
    endtask

    task automatic reset_obs();
        first_acc = -1; first_ret = -1; obs_acc = 0; obs_ret = 0; obs_peak = 0;
        obs_ready_seen = 0;
    endtask

    // One cycle: called at a negedge with inputs set; checks outputs, then advances the model.
    task automatic tick();
        bit exp_ready, acc, ret, idle, all_sent;
        int ret_tid, ridx;
        d_tid = TID_W'(m_sent);
        #2;
        idle      = !m_open && !m_done;
        exp_ready = m_open && (m_sent < m_num) && !d_stall;
        acc       = exp_ready && d_valid;
        ret = 0; ret_tid = 0; ridx = -1;
        if (m_open && m_lat == 0) begin
            ret = acc; ret_tid = acc ? int'(d_tid) : 0;
        end else if (!d_stall) begin
            foreach (m_age[i]) if (m_age[i] == m_lat) begin
                ret = 1; ret_tid = m_tidq[i]; ridx = i;
            end
        end
        check("in_ready",   32'(ifc.in_ready),  32'(exp_ready));
        check("out_valid",  32'(ifc.out_valid), 32'(ret));
        check("out_tid",    32'(ifc.out_tid),   ret_tid);
        check("inflight",   32'(inflight),      m_sent - m_got);
        check("busy",       32'(busy),          32'(!idle));
        check("batch_done", 32'(batch_done),    32'(m_done));
`ifdef DICE_TID_PIPE_PERF_EN
        check("perf_stall",  perf_stall,  m_pstall);
        check("perf_bubble", perf_bubble, m_pbub);
`endif
        if (ifc.in_ready && d_valid) begin obs_acc++; if (first_acc < 0) first_acc = cyc; end
        if (ifc.out_valid) begin obs_ret++; if (first_ret < 0) first_ret = cyc; end
        if (int'(inflight) > obs_peak) obs_peak = int'(inflight);
        if (ifc.in_ready) obs_ready_seen = 1;
        cyc++;

        if (!rst_n || d_clr || (idle && d_start)) begin
            m_pstall = 0; m_pbub = 0;
        end else begin
            if (!idle && d_stall) m_pstall++;
            if (exp_ready && !d_valid) m_pbub++;
        end
        if (!rst_n || d_clr) begin
            model_clear();
        end else if (m_done) begin
            m_done = 0;
        end else if (idle) begin
            if (d_start) begin
                m_num = int'(d_num);
                m_lat = (int'(d_lat) > int'(MAX_LATENCY)) ? int'(MAX_LATENCY) : int'(d_lat);
                m_sent = 0; m_got = 0;
                m_age.delete(); m_tidq.delete();
                if (m_num == 0) m_done = 1; else m_open = 1;
            end
        end else begin
            all_sent = (m_sent == m_num);
            if (ridx >= 0) begin m_age.delete(ridx); m_tidq.delete(ridx); end
            if (!d_stall) foreach (m_age[i]) m_age[i]++;
            if (acc) begin
                m_sent++;
                if (m_lat != 0) begin m_age.push_back(1); m_tidq.push_back(int'(d_tid)); end
            end
            if (ret) m_got++;
            if (all_sent && m_got == m_num) begin m_open = 0; m_done = 1; end
        end
        @(negedge clk);
    endtask

    // Dispatcher holds in_valid until accepted; otherwise raises it with probability (100-idle_pct)%.
    task automatic finish_batch(input int stall_pct, input int idle_pct, input int budget);
        int n = 0;
        bit last_acc = 0;
        while ((m_open || m_done) && n < budget) begin
            d_stall = ($urandom_range(99) < 32'(stall_pct));
            if (!d_valid || last_acc) d_valid = ($urandom_range(99) >= 32'(idle_pct));
            last_acc = d_valid && m_open && (m_sent < m_num) && !d_stall;
            tick();
            n++;
        end
        check("batch_completes", 32'(n < budget), 32'd1);
        d_valid = 0; d_stall = 0;
        tick();
    endtask

    task automatic start_batch(input int num, input int lat);
        reset_obs();
        d_start = 1; d_num = CNT_W'(num); d_lat = LAT_W'(lat);
        tick();
        d_start = 0;
    endtask

    initial begin
        rst_n = 0; d_clr = 0; d_start = 0; d_stall = 0; d_valid = 0;
        d_num = '0; d_lat = '0; d_tid = '0; cyc = 0;
        model_clear(); reset_obs();
        @(negedge clk);
        tick(); tick();
        rst_n = 1;
        tick();

        // num=4 lat=3, valid held: retires 3 cycles after accept, peak inflight 3
        start_batch(4, 3);
        finish_batch(0, 0, 40);
        check("t1_peak_inflight", obs_peak, 3);
        check("t1_retired", obs_ret, 4);
        check("t1_latency", first_ret - first_acc, 3);

        // lat=3 num=2, 2-cycle stall while TID 0 is in stage 1: emitted once, 2 cycles late
        start_batch(2, 3);
        d_valid = 1; tick(); tick();
        d_valid = 0; d_stall = 1; tick(); tick();
        d_stall = 0;
        finish_batch(0, 100, 40);
        check("t2_accepted", obs_acc, 2);
        check("t2_retired", obs_ret, 2);
        check("t2_latency", first_ret - first_acc, 5);

        // lat=0 bypass with a stall pulse
        start_batch(3, 0);
        d_valid = 1; tick();
        d_stall = 1; tick();
        d_stall = 0; tick(); tick();
        finish_batch(0, 100, 20);
        check("t3_retired", obs_ret, 3);
        check("t3_latency", first_ret - first_acc, 0);

        // empty batch: done pulse, never ready
        start_batch(0, 5);
        finish_batch(0, 0, 10);
        check("t4_no_ready", 32'(obs_ready_seen), 32'd0);

        // clr with 3 in flight
        start_batch(8, 5);
        d_valid = 1; tick(); tick(); tick();
        check("t5_inflight_pre_clr", 32'(inflight), 32'd3);
        d_clr = 1; tick();
        d_clr = 0; d_valid = 0; tick(); tick();

        // start while running is ignored; latency stays 4
        start_batch(6, 4);
        d_valid = 1; tick(); tick();
        d_start = 1; d_lat = LAT_W'(10); d_num = CNT_W'(2); tick();
        d_start = 0;
        finish_batch(0, 0, 60);
        check("t6_retired", obs_ret, 6);
        check("t6_latency", first_ret - first_acc, 4);

        // latency 40 saturates to MAX_LATENCY
        start_batch(3, 40);
        finish_batch(0, 0, 200);
        check("t7_latency_sat", first_ret - first_acc, int'(MAX_LATENCY));

        // randomized batches
        for (int b = 0; b < 10; b++) begin
            start_batch(int'($urandom_range(1, 20)), int'($urandom_range(0, 40)));
            finish_batch(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 2000);
            check("rand_retired", obs_ret, obs_acc);
        end

        // asynchronous reset mid-batch
        start_batch(5, 6);
        d_valid = 1; tick(); tick(); tick(); tick();
        rst_n = 0; #1;
        check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_inflight", 32'(inflight), 32'd0);
        check("arst_batch_done", 32'(batch_done), 32'd0);
        d_valid = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dice_cgra_tid_pipeline.md
Name: dice_cgra_tid_pipeline

Overview:
- Next-generation thread-ID latency pipeline for the DICE CGRA subsystem. It tracks each dispatched TID through the configurable CGRA compute latency and presents it at writeback time.
- Over the first-generation TID shift register it adds: batch-level control with a state machine, a ready/valid dispatch handshake, a global stall that freezes the pipe, in-flight and retire accounting, and a batch-done pulse.
- Sits between the dispatcher and the RF write-address converter.

Parameters:
- NUM_TID, 512, threads per batch; TID_W = $clog2(NUM_TID+1)
- MAX_LATENCY, 32, maximum CGRA pipeline depth; LAT_W = $clog2(MAX_LATENCY+1)
- CNT_W, $clog2(NUM_TID+1), width of the dispatch, retire and in-flight counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear; same effect as reset
- start  in  1  batch start pulse; honoured only in IDLE
- cfg_num_tid  in  CNT_W  TIDs in the batch; sampled on accepted start
- cfg_latency  in  LAT_W  compute latency; sampled on accepted start
- stall  in  1  writeback backpressure; freezes the pipe
- in_tid  in  TID_W  dispatched TID
- in_valid  in  1  dispatch valid
- in_ready  out  1  dispatch accept
- out_tid  out  TID_W  TID at writeback
- out_valid  out  1  writeback valid
- inflight  out  CNT_W  accepted but not yet retired
- busy  out  1  state != IDLE
- batch_done  out  1  one-cycle pulse on batch completion

Behaviour:
- Reset / clr: state IDLE; all pipe valids 0; counters 0; lat_q 0, num_q 0. Outputs in_ready=0, out_valid=0, out_tid=0, inflight=0, busy=0, batch_done=0. clr outranks every other input in the same cycle.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start: capture lat_q and num_q; clear disp_cnt and ret_cnt. If cfg_num_tid=0, go IDLE→DONE instead.
  - RUN→DRAIN when the accepted TID makes disp_cnt==num_q.
  - DRAIN→DONE when ret_cnt==num_q (counting this cycle's retire).
  - DONE→IDLE unconditionally. batch_done=1 only while in DONE.
  - start outside IDLE is ignored.
- Handshake:
  - in_ready = (state==RUN) & !stall & (disp_cnt<num_q).
  - Accept = in_valid & in_ready. in_valid without in_ready has no effect; the dispatcher holds.
- Pipe: MAX_LATENCY stages of {valid, tid}.
  - When !stall: stage0 <= {accept, in_tid}; stage[i] <= stage[i-1].
  - When stall: all stages hold.
  - Output tap is stage[lat_q-1].
  - out_valid = tap.valid & !stall. A stalled cycle must never produce a writeback; the held entry emits once after release.
  - out_tid = tap.tid when out_valid, else 0.
- lat_q=0: combinational bypass. out_valid=accept, out_tid=in_tid. A stall blocks accept, so nothing is emitted.
- lat_q > MAX_LATENCY at start: saturate to MAX_LATENCY.
- Counters:
  - disp_cnt +1 on accept; ret_cnt +1 on out_valid.
  - inflight = disp_cnt - ret_cnt (registered counter). Accept and retire in the same cycle leave it unchanged.
  - Counters never wrap, because disp_cnt ≤ num_q ≤ NUM_TID.
- Asynchronous reset mid-batch: abandon the batch, drop all in-flight entries, no batch_done.

Optional Feature:
- DICE_TID_PIPE_PERF_EN defined: adds 32-bit outputs perf_stall_cycles (cycles with busy & stall) and perf_bubble_cycles (RUN cycles with in_ready & !in_valid). Both cleared by reset, clr and accepted start; both saturate at all-ones.
- Not defined: the ports and the counters are absent.

Decomposition:
- Package dice_cgra_pkg holds: the state enum tid_pipe_state_e {IDLE, RUN, DRAIN, DONE}, the TID_W and LAT_W localparam functions, and the struct tid_slot_t {valid, tid}.
- One sub-module, dice_tid_delay_line: a stall-able variable-tap shift register with MAX_LATENCY stages of tid_slot_t. Lat 0 bypass and stall gating of out_valid stay in the parent.

Test Plan:
- start, num=4, lat=3, in_valid held with TIDs 0..3 → accepted on cycles 1..4, out_valid cycles 4..7 with TIDs 0..3, DRAIN after cycle 4, batch_done one cycle after the last retire, inflight peak 3.
- lat=3, num=2, stall asserted for 2 cycles while TID 0 sits in stage 1 → no out_valid during the stall, TID 0 emitted exactly once 2 cycles late, disp/ret counts both 2.
- lat=0, num=3 → out_valid same cycle as accept; stall pulse → in_ready=0, no output that cycle.
- start with num=0 → DONE the next cycle, batch_done pulse, no in_ready ever high.
- Mid-batch clr with 3 in flight → next cycle IDLE, out_valid 0, inflight 0, no batch_done; a second start in RUN is ignored with lat_q unchanged.
- lat=40 with MAX_LATENCY=32 → latency observed is 32 cycles.
